snake_logic: RTL
================

Name: snake_logic

Overview:
Logic datapath for the snake game. It consumes the controller's tick/no-update strobes and current direction. On each tick it advances the snake one cell, detects body collisions, and grows the snake on food. It requests new food positions from the PRNG through a req/valid handshake, drives LOGIC_DONE/GAME_END back to the controller, and produces the 64-bit LED image the controller multiplexes onto the display.

Parameters:
INIT_FOOD, 30, food cell index after reset (row 3, col 6).
MAX_FOOD_TRIES, 8, PRNG draws accepted per food placement before falling back to linear scan.

Ports:
clka  input  1  sole clock; all state updates on rising edge.
restart  input  1  reset, asynchronous, active-high.
to_logic  input  2  [0]=LOGIC_TICK, [1]=NO_UPDATE.
direction_state  input  2  0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
rand_data  input  6  PRNG candidate cell index.
rand_valid  input  1  rand_data valid this cycle.
rand_req  output  1  request for a PRNG value.
from_logic  output  2  [0]=LOGIC_DONE, [1]=GAME_END.
led_array_flat  output  64  bit (row*8+col) lit; row 0 is bottom, col 0 is left.

Behaviour:
- Cell index: 6 bits = {row[2:0], col[2:0]}.
- Direction moves: UP row+1; DOWN row-1; LEFT col-1; RIGHT col+1. All arithmetic is mod 8, so the snake wraps around the board edges. Walls never end the game.
- Body storage:
  - 64x6 circular buffer, head_ptr (6b), length (7b, 1..64).
  - tail index = head_ptr-(length-1) mod 64.
  - 64-bit occupancy map mirrors the buffer contents.
- Reset (async, any state):
  - buffer[0..2] = 25, 26, 27; head_ptr = 2; length = 3.
  - occupancy bits {25,26,27} set; food = INIT_FOOD; food_valid = 1.
  - blink = 0; game_over = 0.
  - from_logic = 0; rand_req = 0; state = IDLE.
- led_array_flat = occupancy | (food_valid ? onehot(food) : 0), with the head bit XORed by blink. It is registered and updates on the same edge as the state it reflects.
- Tick detection: to_logic[0] is registered and its rising edge is detected. Only a detected edge in IDLE starts work. On that edge LOGIC_DONE is cleared. Edges seen outside IDLE are ignored.
- FSM states:
  - IDLE: on tick edge:
    - if game_over or NO_UPDATE: toggle blink, set LOGIC_DONE next edge, stay IDLE (latency 1).
    - otherwise go to CHECK.
  - CHECK:
    - compute nxt = head moved by direction_state; eat = food_valid && nxt==food.
    - hit = occupancy[nxt] && !(nxt==tail && !eat). Moving into the vacating tail cell is legal.
    - if hit: game_over = 1, GAME_END = 1, LOGIC_DONE = 1, go to IDLE. The board is unchanged.
    - otherwise go to COMMIT.
  - COMMIT:
    - write nxt at head_ptr+1; set occupancy[nxt].
    - if !eat: clear occupancy[tail] (unless tail==nxt), length unchanged, LOGIC_DONE = 1, go to IDLE.
    - if eat: length+1 and food_valid = 0.
      - new length 64: game_over = 1, GAME_END = 1, LOGIC_DONE = 1, go to IDLE.
      - otherwise go to FOOD_REQ.
  - FOOD_REQ:
    - rand_req = 1 until a cycle with rand_req && rand_valid.
    - accept rand_data and increment tries.
    - if the accepted cell is free: food = rand_data, food_valid = 1, rand_req = 0, LOGIC_DONE = 1, go to IDLE.
    - if occupied and tries < MAX_FOOD_TRIES: drop rand_req one cycle, then re-request.
    - otherwise rand_req = 0, go to FOOD_SCAN with cursor = rand_data+1.
  - FOOD_SCAN: examine one cell per cycle, wrapping mod 64. The first free cell becomes food; then LOGIC_DONE = 1, go to IDLE. A free cell is guaranteed because length < 64.
- Timing: a non-eating move gives LOGIC_DONE high 2 edges after the tick-sampling edge.
- LOGIC_DONE is held until the next detected tick. GAME_END is sticky until restart.
- direction_state is sampled only in CHECK. The block does not filter reversals; a reversal is a body hit.
- restart mid-operation (including FOOD_REQ/FOOD_SCAN) immediately forces reset values; rand_req drops asynchronously.

Test Plan:
- Reset -> led_array_flat = 64'h000000004E000000, from_logic = 0, rand_req = 0.
- Reset, direction RIGHT, one tick -> LOGIC_DONE rises 2 edges after tick sample; led = 64'h000000005C000000 (bits 26, 27, 28, 30).
- Two more RIGHT ticks:
  - second tick eats food at 30; rand_req rises.
  - PRNG supplies 27 (occupied), then 0 -> rand_req drops, re-asserts, accepts 0.
  - LOGIC_DONE rises; led = 64'h0000000078000001; length 4.
- Reset, five UP ticks -> head wraps to index 3; led bits {3, 51, 59, 30} only; GAME_END = 0.
- Reset, one LEFT tick -> GAME_END = 1 and LOGIC_DONE = 1 from CHECK; led stays 64'h000000004E000000.
  - Then tick with NO_UPDATE -> led 64'h0000000046000000 after 1 edge; next tick -> 64'h000000004E000000.
- Eat food, then assert restart while rand_req = 1 -> rand_req = 0 and from_logic = 0 immediately; led returns to 64'h000000004E000000.
  - Force PRNG to return occupied cells 8 times -> FOOD_SCAN picks the next free index after the last candidate.

Source files
------------

// File: rtl/snake_logic.sv
// snake_logic: snake game datapath - movement, body collision, growth, food placement and LED image
module snake_logic #(
  parameter int INIT_FOOD      = 30,
  parameter int MAX_FOOD_TRIES = 8
) (
  input  logic        clka,
  input  logic        restart,
  input  logic [1:0]  to_logic,
  input  logic [1:0]  direction_state,
  input  logic [5:0]  rand_data,
  input  logic        rand_valid,
  output logic        rand_req,
  output logic [1:0]  from_logic,
  output logic [63:0] led_array_flat
);
  typedef enum logic [2:0] {IDLE, CHECK, COMMIT, FOOD_REQ, FOOD_SCAN} state_t;
  localparam logic [7:0]  max_tries = 8'(MAX_FOOD_TRIES);
  localparam logic [5:0]  init_food = 6'(INIT_FOOD);
  localparam logic [63:0] init_occ  = 64'h0000_0000_0E00_0000;
  state_t      state, state_n;
  logic [5:0]  body [64];
  logic [5:0]  head_ptr, head_ptr_n, head, head_n, food, food_n, nxt, nxt_n;
  logic [5:0]  cursor, cursor_n, tail, mv;
  logic [6:0]  length, length_n;
  logic [63:0] occ, occ_n, led_n;
  logic [7:0]  tries, tries_n;
  logic        food_valid, fv_n, blink, blink_n, game_over, go_n, done, done_n, pend, pend_n;
  logic        eat, eat_n, req_n, tick_q, tick_edge, mv_eat, hit, wr;
  assign tail       = body[head_ptr - 6'(length - 7'd1)];
  assign tick_edge  = to_logic[0] & ~tick_q;
  assign from_logic = {game_over, done};
  assign mv = direction_state == 2'd0 ? {head[5:3] + 3'd1, head[2:0]} :
              direction_state == 2'd1 ? {head[5:3] - 3'd1, head[2:0]} :
              direction_state == 2'd2 ? {head[5:3], head[2:0] - 3'd1} :
                                        {head[5:3], head[2:0] + 3'd1};
  assign mv_eat = food_valid && mv == food;
  // The tail cell vacates on the same commit, so stepping into it is legal unless the snake grows
  assign hit    = occ[mv] && !(mv == tail && !mv_eat);
  always_comb begin
    state_n    = state;
    head_ptr_n = head_ptr;
    head_n     = head;
    food_n     = food;
    fv_n       = food_valid;
    nxt_n      = nxt;
    eat_n      = eat;
    cursor_n   = cursor;
    length_n   = length;
    occ_n      = occ;
    tries_n    = tries;
    blink_n    = blink;
    go_n       = game_over;
    done_n     = done;
    pend_n     = 1'b0;
    req_n      = rand_req;
    wr         = 1'b0;
    case (state)
      IDLE: begin
        done_n = done | pend;
        if (tick_edge) begin
          done_n = 1'b0;
          if (game_over || to_logic[1]) begin
            blink_n = ~blink;
            pend_n  = 1'b1;
          end else state_n = CHECK;
        end
      end
      CHECK: begin
        nxt_n = mv;
        eat_n = mv_eat;
        if (hit) begin
          go_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else state_n = COMMIT;
      end
      COMMIT: begin
        wr         = 1'b1;
        head_ptr_n = head_ptr + 6'd1;
        head_n     = nxt;
        occ_n      = (occ & ~(eat ? 64'd0 : 64'd1 << tail)) | (64'd1 << nxt);
        if (!eat) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          length_n = length + 7'd1;
          fv_n     = 1'b0;
          tries_n  = 8'd0;
          if (length == 7'd63) begin
            go_n    = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            req_n   = 1'b1;
            state_n = FOOD_REQ;
          end
        end
      end
      FOOD_REQ: begin
        if (!rand_req) req_n = 1'b1;
        else if (rand_valid) begin
          tries_n = tries + 8'd1;
          req_n   = 1'b0;
          if (!occ[rand_data]) begin
            food_n  = rand_data;
            fv_n    = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end else if (tries + 8'd1 >= max_tries) begin
            cursor_n = rand_data + 6'd1;
            state_n  = FOOD_SCAN;
          end
        end
      end
      FOOD_SCAN: begin
        if (!occ[cursor]) begin
          food_n  = cursor;
          fv_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else cursor_n = cursor + 6'd1;
      end
      default: state_n = IDLE;
    endcase
    led_n = (occ_n | (fv_n ? 64'd1 << food_n : 64'd0)) ^ (blink_n ? 64'd1 << head_n : 64'd0);
  end
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state          <= IDLE;
      body[0]        <= 6'd25;
      body[1]        <= 6'd26;
      body[2]        <= 6'd27;
      head_ptr       <= 6'd2;
      head           <= 6'd27;
      length         <= 7'd3;
      occ            <= init_occ;
      food           <= init_food;
      food_valid     <= 1'b1;
      nxt            <= 6'd0;
      eat            <= 1'b0;
      cursor         <= 6'd0;
      tries          <= 8'd0;
      blink          <= 1'b0;
      game_over      <= 1'b0;
      done           <= 1'b0;
      pend           <= 1'b0;
      rand_req       <= 1'b0;
      tick_q         <= 1'b0;
      led_array_flat <= init_occ | (64'd1 << init_food);
    end else begin
      state          <= state_n;
      head_ptr       <= head_ptr_n;
      head           <= head_n;
      length         <= length_n;
      occ            <= occ_n;
      food           <= food_n;
      food_valid     <= fv_n;
      nxt            <= nxt_n;
      eat            <= eat_n;
      cursor         <= cursor_n;
      tries          <= tries_n;
      blink          <= blink_n;
      game_over      <= go_n;
      done           <= done_n;
      pend           <= pend_n;
      rand_req       <= req_n;
      tick_q         <= to_logic[0];
      led_array_flat <= led_n;
      if (wr) body[head_ptr + 6'd1] <= nxt;
    end
  end
endmodule
